// File: rtl/core_pkg.sv
// core_pkg: shared definitions for the load/store unit.
//   - SZ_B / SZ_H / SZ_W (SZ_X illegal) : access size encodings on SIZE
//   - lsu_state_e                       : FSM state encoding
//   - cnt_width()                       : timeout counter width for a TIMEOUT value
//   - access_bad()                      : misalignment / illegal-size test
package core_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_e;

  // Counter must be able to hold the value TIMEOUT itself.
  function automatic int cnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

  // 1 when the access cannot be issued: misaligned half/word or SIZE=11.
  function automatic logic access_bad(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = addr_lo[0];
      SZ_W:    bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/core_lsu_align.sv
// core_lsu_align: combinational data-path helpers for the load/store unit.
//   size, addr_lo, is_unsigned : latched access attributes
//   wdata     : right-justified store data
//   rdata     : raw word from memory
//   be        : byte enables for the access
//   wdata_rep : store data replicated across the lanes selected by be
//   ld_data   : lane-extracted, sign/zero-extended load result
module core_lsu_align
  import core_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] ld_data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    be = 4'b1111;
    case (size)
      SZ_B:    be = 4'b0001 << addr_lo;
      SZ_H:    be = 4'b0011 << {addr_lo[1], 1'b0};
      default: be = 4'b1111;
    endcase
  end

  // Each byte lane picks its source: the low byte for byte stores, the
  // matching byte of the low half for half stores, itself for words.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      always_comb begin
        case (size)
          SZ_B:    wdata_rep[8*gi +: 8] = wdata[7:0];
          SZ_H:    wdata_rep[8*gi +: 8] = wdata[8*(gi%2) +: 8];
          default: wdata_rep[8*gi +: 8] = wdata[8*gi +: 8];
        endcase
      end
    end
  endgenerate

  always_comb begin
    byte_lane = rdata[{addr_lo, 3'b000} +: 8];
    half_lane = rdata[{addr_lo[1], 4'b0000} +: 16];
    case (size)
      SZ_B:    ld_data = is_unsigned ? {24'd0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
      SZ_H:    ld_data = is_unsigned ? {16'd0, half_lane} : {{16{half_lane[15]}}, half_lane};
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/core_lsu.sv
// core_lsu: load/store unit between the memory stage and the data port.
//   Core side  : REQ, WE, SIZE, UNSIGNED, ADDR, WDATA in; BUSY, DONE, ERR, RDATA out
//   Memory side: D_REQ, D_ADDR, D_WE, D_BE, D_WDATA out; D_READY, D_RDATA in
//   TIMEOUT    : cycles D_REQ may wait for D_READY before the access is aborted
// One request at a time: IDLE -> ACCESS (memory handshake) -> RESP (DONE pulse).
// Bad requests skip ACCESS and go straight to RESP with ERR.
module core_lsu
  import core_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        REQ,
  input  logic        WE,
  input  logic [1:0]  SIZE,
  input  logic        UNSIGNED,
  input  logic [31:0] ADDR,
  input  logic [31:0] WDATA,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [31:0] RDATA,
  output logic        D_REQ,
  output logic [31:0] D_ADDR,
  output logic        D_WE,
  output logic [3:0]  D_BE,
  output logic [31:0] D_WDATA,
  input  logic        D_READY,
  input  logic [31:0] D_RDATA
);

  localparam int CNT_W = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  lsu_state_e        state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              err_reg, err_next;

  logic              we_reg;
  logic [1:0]        size_reg;
  logic              uns_reg;
  logic [31:0]       addr_reg;
  logic [31:0]       wdata_reg;
  logic [31:0]       rdata_reg;

  logic              accept;
  logic              in_access;
  logic [3:0]        be;
  logic [31:0]       wdata_rep;
  logic [31:0]       ld_data;

  assign accept    = (state_reg == ST_IDLE) && REQ;
  assign in_access = (state_reg == ST_ACCESS);

  core_lsu_align u_align (
    .size        (size_reg),
    .addr_lo     (addr_reg[1:0]),
    .is_unsigned (uns_reg),
    .wdata       (wdata_reg),
    .rdata       (D_RDATA),
    .be          (be),
    .wdata_rep   (wdata_rep),
    .ld_data     (ld_data)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    err_next   = err_reg;
    case (state_reg)
      ST_IDLE: begin
        if (REQ) begin
          err_next   = access_bad(SIZE, ADDR[1:0]);
          cnt_next   = '0;
          state_next = err_next ? ST_RESP : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        // A late D_READY in the final allowed cycle still wins over the abort.
        if (D_READY) begin
          state_next = ST_RESP;
        end else if (cnt_reg == CNT_LAST) begin
          err_next   = 1'b1;
          state_next = ST_RESP;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ST_RESP: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Request attributes are frozen for the whole transaction so the memory
  // side sees stable address/enables/data until D_READY.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      we_reg    <= 1'b0;
      size_reg  <= SZ_B;
      uns_reg   <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
    end else begin
      if (accept) begin
        we_reg    <= WE;
        size_reg  <= SIZE;
        uns_reg   <= UNSIGNED;
        addr_reg  <= ADDR;
        wdata_reg <= WDATA;
      end
      if (in_access && D_READY && !we_reg) begin
        rdata_reg <= ld_data;
      end
    end
  end

  // The memory bus is driven only while a request is outstanding.
  assign D_REQ   = in_access;
  assign D_ADDR  = in_access ? {addr_reg[31:2], 2'b00} : 32'd0;
  assign D_WE    = in_access && we_reg;
  assign D_BE    = in_access ? be : 4'b0000;
  assign D_WDATA = (in_access && we_reg) ? wdata_rep : 32'd0;

  assign BUSY  = (state_reg != ST_IDLE);
  assign DONE  = (state_reg == ST_RESP);
  assign ERR   = (state_reg == ST_RESP) && err_reg;
  assign RDATA = rdata_reg;

endmodule

// File: tb/tb_core_lsu.sv
module tb_core_lsu;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        REQ;
  logic        WE;
  logic [1:0]  SIZE;
  logic        UNSIGNED;
  logic [31:0] ADDR;
  logic [31:0] WDATA;
  logic        BUSY;
  logic        DONE;
  logic        ERR;
  logic [31:0] RDATA;
  logic        D_REQ;
  logic [31:0] D_ADDR;
  logic        D_WE;
  logic [3:0]  D_BE;
  logic [31:0] D_WDATA;
  logic        D_READY;
  logic [31:0] D_RDATA;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  core_lsu #(.TIMEOUT(4)) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .REQ      (REQ),
    .WE       (WE),
    .SIZE     (SIZE),
    .UNSIGNED (UNSIGNED),
    .ADDR     (ADDR),
    .WDATA    (WDATA),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .ERR      (ERR),
    .RDATA    (RDATA),
    .D_REQ    (D_REQ),
    .D_ADDR   (D_ADDR),
    .D_WE     (D_WE),
    .D_BE     (D_BE),
    .D_WDATA  (D_WDATA),
    .D_READY  (D_READY),
    .D_RDATA  (D_RDATA)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present a request for one cycle; returns in cycle 1 of the transaction.
  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd);
    REQ = 1'b1; WE = we; SIZE = sz; UNSIGNED = uns; ADDR = addr; WDATA = wd;
    $display("txn: we=%0b size=%0d uns=%0b addr=%h wdata=%h", we, sz, uns, addr, wd);
    tick();
    REQ = 1'b0;
  endtask

  initial begin
    RST_N = 1'b0; REQ = 1'b0; WE = 1'b0; SIZE = 2'b00; UNSIGNED = 1'b0;
    ADDR = '0; WDATA = '0; D_READY = 1'b0; D_RDATA = '0;
    #12;
    chk("rst_busy",  BUSY,  0);
    chk("rst_done",  DONE,  0);
    chk("rst_err",   ERR,   0);
    chk("rst_rdata", RDATA, 0);
    chk("rst_dreq",  D_REQ, 0);
    chk("rst_dbe",   D_BE,  0);
    @(posedge CLK); #1; RST_N = 1'b1;
    tick();

    // LW 0x100, zero-wait memory
    D_READY = 1'b1; D_RDATA = 32'hDEADBEEF;
    issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    chk("lw_c1_dreq",  D_REQ,  1);
    chk("lw_c1_daddr", D_ADDR, 32'h100);
    chk("lw_c1_dbe",   D_BE,   4'b1111);
    chk("lw_c1_dwe",   D_WE,   0);
    chk("lw_c1_done",  DONE,   0);
    tick();
    chk("lw_c2_done",  DONE,  1);
    chk("lw_c2_err",   ERR,   0);
    chk("lw_c2_rdata", RDATA, 32'hDEADBEEF);
    chk("lw_c2_dreq",  D_REQ, 0);
    tick();
    chk("lw_c3_busy",  BUSY,  0);
    chk("lw_c3_done",  DONE,  0);

    // LB / LBU at 0x103, top byte 0x80
    D_RDATA = 32'h80123456;
    issue(1'b0, 2'b00, 1'b0, 32'h103, 32'h0);
    chk("lb_daddr", D_ADDR, 32'h100);
    chk("lb_dbe",   D_BE,   4'b1000);
    tick();
    chk("lb_done",  DONE,  1);
    chk("lb_rdata", RDATA, 32'hFFFFFF80);
    tick();
    issue(1'b0, 2'b00, 1'b1, 32'h103, 32'h0);
    chk("lbu_dbe",  D_BE, 4'b1000);
    tick();
    chk("lbu_rdata", RDATA, 32'h00000080);
    tick();

    // SH 0x202 with 3 wait cycles
    D_READY = 1'b0;
    issue(1'b1, 2'b01, 1'b0, 32'h202, 32'h1234ABCD);
    for (int c = 1; c <= 3; c++) begin
      chk("sh_wait_dreq", D_REQ,   1);
      chk("sh_wait_dwd",  D_WDATA, 32'hABCDABCD);
      tick();
    end
    D_READY = 1'b1;
    chk("sh_c4_dreq",  D_REQ,   1);
    chk("sh_c4_dbe",   D_BE,    4'b1100);
    chk("sh_c4_dwe",   D_WE,    1);
    chk("sh_c4_daddr", D_ADDR,  32'h200);
    chk("sh_c4_dwd",   D_WDATA, 32'hABCDABCD);
    chk("sh_c4_done",  DONE,    0);
    tick();
    chk("sh_c5_done",  DONE,  1);
    chk("sh_c5_err",   ERR,   0);
    chk("sh_c5_rdata", RDATA, 32'h00000080);
    tick();

    // LH 0x102 (signed, upper half) and LHU 0x100 (lower half)
    D_RDATA = 32'h80017FFF;
    issue(1'b0, 2'b01, 1'b0, 32'h102, 32'h0);
    chk("lh_dbe", D_BE, 4'b1100);
    tick();
    chk("lh_rdata", RDATA, 32'hFFFF8001);
    tick();
    issue(1'b0, 2'b01, 1'b1, 32'h100, 32'h0);
    chk("lhu_dbe", D_BE, 4'b0011);
    tick();
    chk("lhu_rdata", RDATA, 32'h00007FFF);
    tick();

    // SB 0x001: byte replication
    issue(1'b1, 2'b00, 1'b0, 32'h001, 32'hFFFFFF5A);
    chk("sb_dbe", D_BE,    4'b0010);
    chk("sb_dwd", D_WDATA, 32'h5A5A5A5A);
    tick();
    chk("sb_rdata", RDATA, 32'h00007FFF);
    tick();

    // Error paths: misaligned LW, illegal size, misaligned SH
    issue(1'b0, 2'b10, 1'b0, 32'h101, 32'h0);
    chk("lw_mis_done",  DONE,  1);
    chk("lw_mis_err",   ERR,   1);
    chk("lw_mis_dreq",  D_REQ, 0);
    tick();
    chk("lw_mis_busy",  BUSY,  0);
    chk("lw_mis_rdata", RDATA, 32'h00007FFF);
    issue(1'b0, 2'b11, 1'b0, 32'h100, 32'h0);
    chk("sz11_done", DONE,  1);
    chk("sz11_err",  ERR,   1);
    chk("sz11_dreq", D_REQ, 0);
    tick();
    issue(1'b1, 2'b01, 1'b0, 32'h201, 32'h0);
    chk("sh_mis_err",  ERR,   1);
    chk("sh_mis_dreq", D_REQ, 0);
    tick();

    // Timeout: D_READY never comes; REQ raised while busy must be ignored
    D_READY = 1'b0;
    issue(1'b0, 2'b10, 1'b0, 32'h300, 32'h0);
    for (int c = 1; c <= 4; c++) begin
      if (c == 2) begin
        REQ = 1'b1; ADDR = 32'h500; SIZE = 2'b11;
      end
      if (c == 4) REQ = 1'b0;
      chk("to_dreq",  D_REQ,  1);
      chk("to_daddr", D_ADDR, 32'h300);
      chk("to_done",  DONE,   0);
      tick();
    end
    chk("to_c5_done",  DONE,  1);
    chk("to_c5_err",   ERR,   1);
    chk("to_c5_dreq",  D_REQ, 0);
    chk("to_c5_rdata", RDATA, 32'h00007FFF);
    tick();
    chk("to_c6_busy",  BUSY,  0);
    tick();
    chk("to_c7_busy",  BUSY,  0);

    // Reset during the ACCESS wait
    issue(1'b0, 2'b10, 1'b0, 32'h400, 32'h0);
    chk("rmid_c1_dreq", D_REQ, 1);
    tick();
    RST_N = 1'b0;
    #1;
    chk("rmid_dreq",  D_REQ, 0);
    chk("rmid_busy",  BUSY,  0);
    chk("rmid_done",  DONE,  0);
    chk("rmid_rdata", RDATA, 0);
    tick();
    chk("rmid_done2", DONE,  0);
    RST_N = 1'b1;
    tick();
    D_READY = 1'b1; D_RDATA = 32'hCAFEF00D;
    issue(1'b0, 2'b10, 1'b0, 32'h104, 32'h0);
    chk("post_dreq",  D_REQ,  1);
    chk("post_daddr", D_ADDR, 32'h104);
    tick();
    chk("post_done",  DONE,  1);
    chk("post_err",   ERR,   0);
    chk("post_rdata", RDATA, 32'hCAFEF00D);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
